// File: rtl/bpsk_player_pkg.sv
// Shared widths, FSM state type and sample type for the BPSK sample player.
package bpsk_player_pkg;

  localparam int DEF_ADDR_W   = 20;
  localparam int DEF_SAMPLE_W = 3;
  localparam int DEF_DIV_W    = 16;
  localparam int DEF_WRAP_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } player_state_t;

  typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/bpsk_sample_player_rate_strobe_gen.sv
// Loadable down-counter: tick on the clear cycle, then once every div+1 clocks.
module rate_strobe_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = clear || (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = div;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bpsk_sample_player.sv
// Sweeps the sample RAM address over a window at a programmable rate and
// re-emits each returned sample with an aligned one-cycle valid strobe.
module bpsk_sample_player
  import bpsk_player_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int DIV_W    = DEF_DIV_W,
  parameter int WRAP_W   = DEF_WRAP_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop_en,
  input  logic [DIV_W-1:0]           rate_div,
  input  logic [ADDR_W-1:0]          start_addr,
  input  logic [ADDR_W-1:0]          end_addr,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [SAMPLE_W-1:0]        mem_data,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       busy,
  output logic                       done,
  output logic [WRAP_W-1:0]          wrap_count,
  output player_state_t              state_dbg
);

  // Output handshake: sample_valid is a one-cycle strobe with sample_out
  // stable in that cycle; there is no ready, the consumer takes every strobe.

  player_state_t state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                iss1_q, iss1_d;
  logic                iss2_q, iss2_d;
  logic                valid_q, valid_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [WRAP_W-1:0]   wrap_q, wrap_d;
  logic                first_q, first_d;
  logic                tick;

  rate_strobe_gen #(
    .DIV_W(DIV_W)
  ) u_rate (
    .clk  (clk),
    .rst  (rst),
    .clear(first_q),
    .div  (div_q),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    start_d    = start_q;
    end_d      = end_q;
    div_d      = div_q;
    mem_addr_d = mem_addr_q;
    wrap_d     = wrap_q;
    first_d    = 1'b0;
    iss1_d     = 1'b0;
    // iss1: address registered toward RAM, iss2: RAM output valid now.
    iss2_d     = iss1_q;
    valid_d    = iss2_q;
    sample_d   = iss2_q ? mem_data : sample_q;

    case (state_q)
      IDLE: begin
        if (start && !stop && (start_addr <= end_addr)) begin
          state_d = RUN;
          start_d = start_addr;
          end_d   = end_addr;
          div_d   = rate_div;
          cur_d   = start_addr;
          wrap_d  = '0;
          first_d = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
        end else if (tick) begin
          mem_addr_d = cur_q;
          iss1_d     = 1'b1;
          // Compare against end first so an all-ones end_addr never overflows.
          if (cur_q == end_q) begin
            if (loop_en) begin
              cur_d = start_q;
              if (wrap_q != '1) begin
                wrap_d = wrap_q + WRAP_W'(1);
              end
            end else begin
              state_d = DRAIN;
            end
          end else begin
            cur_d = cur_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!iss1_q && !iss2_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      start_q    <= '0;
      end_q      <= '0;
      div_q      <= '0;
      mem_addr_q <= '0;
      iss1_q     <= 1'b0;
      iss2_q     <= 1'b0;
      valid_q    <= 1'b0;
      sample_q   <= '0;
      wrap_q     <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      start_q    <= start_d;
      end_q      <= end_d;
      div_q      <= div_d;
      mem_addr_q <= mem_addr_d;
      iss1_q     <= iss1_d;
      iss2_q     <= iss2_d;
      valid_q    <= valid_d;
      sample_q   <= sample_d;
      wrap_q     <= wrap_d;
      first_q    <= first_d;
    end
  end

  // The final strobe of a run is the cycle the pipeline has just emptied.
  assign done         = (state_q == DRAIN) && !iss1_q && !iss2_q;
  assign busy         = (state_q != IDLE);
  assign mem_addr     = mem_addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign wrap_count   = wrap_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/bpsk_sample_player.md
# bpsk_sample_player

Playback controller that sits directly upstream of the 3-bit BPSK sample RAM in the Costas-loop test chain. It sweeps the RAM address over a configurable window at a programmable sample rate and accounts for the RAM's one-cycle registered read. It then re-emits each returned signed sample with an aligned valid strobe for the downstream loop. It supports one-shot and looped playback, an abort input, and a wrap counter.

## Interface
- ADDR_W, 20, RAM address width
- SAMPLE_W, 3, sample width (two's complement)
- DIV_W, 16, rate divider width
- WRAP_W, 16, wrap counter width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse; begin playback (ignored while busy)
- stop  in  1  single-cycle pulse; abort playback
- loop_en  in  1  live; 1 = wrap to start_addr after end_addr
- rate_div  in  DIV_W  one read issued every rate_div+1 clocks; latched at start
- start_addr  in  ADDR_W  first address; latched at start
- end_addr  in  ADDR_W  last address (inclusive); latched at start
- mem_addr  out  ADDR_W  registered address to RAM
- mem_data  in  SAMPLE_W  RAM data_out (valid one clock after mem_addr is sampled)
- sample_out  out  SAMPLE_W  signed sample, held between valids
- sample_valid  out  1  one-cycle strobe per sample
- busy  out  1  playback or drain in progress
- done  out  1  one-cycle pulse at end of run
- wrap_count  out  WRAP_W  completed loops of the current run, saturating

## Operation
- Reset values: mem_addr 0, sample_out 0, sample_valid 0, busy 0, done 0, wrap_count 0, state IDLE, pipeline empty.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start with start_addr <= end_addr and stop low → RUN.
  - On entry to RUN: latch config, cur_addr = start_addr, div_cnt = 0, wrap_count = 0.
  - start with start_addr > end_addr is ignored; no done.
  - start and stop in the same cycle: stop wins; stay IDLE.
- RUN, when div_cnt == 0: issue a read.
  - mem_addr <= cur_addr; the issue strobe enters the pipeline.
  - div_cnt <= rate_div.
  - Advance cur_addr.
- RUN, otherwise: div_cnt decrements.
- Advance after issuing end_addr:
  - loop_en = 1: cur_addr = start_addr; wrap_count += 1, saturating at all-ones.
  - loop_en = 0: → DRAIN.
- Address arithmetic: unsigned ADDR_W. end_addr = 2^ADDR_W − 1 never overflows cur_addr, because the advance checks end_addr first. A single-address window (start_addr == end_addr) is legal.
- stop in RUN → DRAIN with no further issues. If stop coincides with an issue slot, that issue is suppressed.
- DRAIN: no issues; waits until the read pipeline is empty, then → IDLE.
- done pulses in the same cycle as the final sample_valid of the run. If no reads are outstanding, done pulses in the first DRAIN cycle.
- busy: high from the cycle after start is accepted up to and including the cycle done pulses; low afterwards.
- sample_out <= mem_data in the capture cycle of each valid; unchanged otherwise.
- mem_addr holds its last value in IDLE.
- Asynchronous reset mid-run: everything returns to reset values and the pipeline is flushed. No done pulse and no sample_valid are produced for in-flight reads.

## Timing
- start sampled at edge E0.
- First issue at E1 (mem_addr = start_addr visible after E1).
- RAM registers the address at E2.
- Capture at E3; sample_valid is high in the cycle after E3.
- General latency: sample_valid is high 2 clocks after mem_addr updates.
- rate_div = 0: one read per clock. Back-to-back sample_valid with no gaps, including across a wrap.
- rate_div = N: sample_valid period is exactly N+1 clocks, including across a wrap.
- Issue pipeline: 2 registered stages (issue → RAM out → sample_valid). No backpressure; downstream must accept every strobe.
- loop_en is sampled at the end_addr issue slot. Clearing it mid-loop finishes the current pass, then drains.

## Structure
- Package bpsk_player_pkg holds:
  - ADDR_W, SAMPLE_W, DIV_W, WRAP_W defaults.
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN} player_state_t.
  - typedef logic signed [SAMPLE_W-1:0] sample_t.
- One sub-module: rate_strobe_gen.
  - Loadable down-counter.
  - Ports: clk, rst, clear, div, tick.
  - tick fires on the clear cycle, then every div+1 clocks.

## Test plan
- rate_div 0, window 0..3, loop_en 0, RAM holding 3'b001, 3'b111, 3'b011, 3'b101 → mem_addr 0,1,2,3 on consecutive clocks; sample_valid ×4 back-to-back with sample_out +1, −1, +3, −3; done coincides with the 4th valid; busy then low.
- rate_div 4, window 10..12, loop_en 1, stop after 8 valids → valid spacing exactly 5 clocks; address sequence 10,11,12,10,11,12,10,11; wrap_count reaches 2; done 0–2 clocks after stop per outstanding reads.
- start_addr 5, end_addr 4 → start ignored: busy, done and sample_valid stay 0; mem_addr unchanged.
- start and stop in the same cycle in IDLE → no activity. start pulsed while busy → no restart; address sequence unaffected.
- Async rst asserted mid-run with 2 reads outstanding → all outputs 0 immediately; no sample_valid or done after release; a subsequent start replays from start_addr.
- Window 0xFFFFE..0xFFFFF, loop_en 1, rate_div 0 → alternating 0xFFFFE/0xFFFFF with no overflow; wrap_count saturates at 0xFFFF after 65535 loops (forced via shortened WRAP_W = 4 → saturates at 15).
